// File: rtl/mastermind_game_ctrl.sv
// Mastermind game sequencer: turns key pulses into seed, load, compare,
// attempt counting and win/lose. Drives LFSR, guess register, comparator.
module mastermind_game_ctrl #(
  parameter int MAX_GUESSES = 8,
  parameter int SPIN_CYCLES = 4,
  parameter int CMP_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       guess,
  input  logic       cmp_done,
  input  logic [2:0] cmp_exact,
  output logic       gen_en,
  output logic       guess_load,
  output logic       cmp_start,
  output logic [3:0] guess_count,
  output logic [2:0] last_exact,
  output logic       win,
  output logic       lose,
  output logic       err,
  output logic       busy,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GEN  = 3'd1,
    S_WAIT = 3'd2,
    S_LOAD = 3'd3,
    S_CMP  = 3'd4,
    S_WIN  = 3'd5,
    S_LOSE = 3'd6
  } state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] gc, gc_n;
  logic [2:0] le, le_n;
  logic       err_r, err_n;
  logic       go_gen;
  logic [3:0] gc_inc;

  assign gc_inc = gc + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      gc    <= '0;
      le    <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gc    <= gc_n;
      le    <= le_n;
      err_r <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gc_n    = gc;
    le_n    = le;
    err_n   = err_r;
    go_gen  = 1'b0;
    unique case (state)
      S_IDLE: go_gen = new_game;
      S_GEN: begin
        if (cnt == 8'(SPIN_CYCLES - 1)) begin
          state_n = S_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_WAIT: begin
        // new_game has priority; a simultaneous guess is dropped
        if (new_game) begin
          go_gen = 1'b1;
        end else if (guess) begin
          state_n = S_LOAD;
          err_n   = 1'b0;
        end
      end
      S_LOAD: begin
        state_n = S_CMP;
        cnt_n   = '0;
      end
      S_CMP: begin
        if (cmp_done) begin
          gc_n = gc_inc;
          le_n = cmp_exact;
          if (cmp_exact == 3'd4)
            state_n = S_WIN;
          else if (gc_inc == 4'(MAX_GUESSES))
            state_n = S_LOSE;
          else
            state_n = S_WAIT;
        end else if (cnt == 8'(CMP_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = S_WAIT;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_WIN:  go_gen = new_game;
      S_LOSE: go_gen = new_game;
      default: state_n = S_IDLE;
    endcase
    if (go_gen) begin
      state_n = S_GEN;
      cnt_n   = '0;
      gc_n    = '0;
      le_n    = '0;
      err_n   = 1'b0;
    end
  end

  assign gen_en      = (state == S_GEN);
  assign guess_load  = (state == S_LOAD);
  assign cmp_start   = (state == S_CMP) && (cnt == 8'd0);
  assign guess_count = gc;
  assign last_exact  = le;
  assign win         = (state == S_WIN);
  assign lose        = (state == S_LOSE);
  assign err         = err_r;
  assign busy        = (state == S_GEN) || (state == S_LOAD) ||
                       (state == S_CMP);
  assign state_o     = state;

endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Scoreboard bench for mastermind_game_ctrl: directed stimulus pushes
// expected per-cycle outputs; a negedge monitor pops and compares.
module tb_mastermind_game_ctrl;

  logic       clk;
  logic       reset;
  logic       new_game;
  logic       guess;
  logic       cmp_done;
  logic [2:0] cmp_exact;
  logic       gen_en;
  logic       guess_load;
  logic       cmp_start;
  logic [3:0] guess_count;
  logic [2:0] last_exact;
  logic       win;
  logic       lose;
  logic       err;
  logic       busy;
  logic [2:0] state_o;

  mastermind_game_ctrl #(
    .MAX_GUESSES(8),
    .SPIN_CYCLES(4),
    .CMP_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .new_game(new_game),
    .guess(guess),
    .cmp_done(cmp_done),
    .cmp_exact(cmp_exact),
    .gen_en(gen_en),
    .guess_load(guess_load),
    .cmp_start(cmp_start),
    .guess_count(guess_count),
    .last_exact(last_exact),
    .win(win),
    .lose(lose),
    .err(err),
    .busy(busy),
    .state_o(state_o)
  );

  typedef struct {
    int          c;
    string       nm;
    logic [16:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] o(
    input bit g, input bit l, input bit s,
    input logic [3:0] gc, input logic [2:0] le,
    input bit w, input bit lo, input bit e,
    input logic [2:0] st);
    bit b;
    b = (st == 3'd1) || (st == 3'd3) || (st == 3'd4);
    return {g, l, s, gc, le, w, lo, e, b, st};
  endfunction

  // monitor: compare whenever the head expectation is due
  always @(negedge clk) begin
    logic [16:0] act;
    exp_t e;
    act = {gen_en, guess_load, cmp_start, guess_count, last_exact,
           win, lose, err, busy, state_o};
    if (q.size() > 0) begin
      if (q[0].c == cyc) begin
        e = q.pop_front();
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", e.nm, cyc, act, e.v);
        end
      end else if (q[0].c < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s missed cyc=%0d got=none want=%h", e.nm, e.c, e.v);
      end
    end
  end

  task automatic tick(input logic r, input logic ng, input logic gs,
                      input logic cd, input logic [2:0] ce,
                      input logic [16:0] ev, input string nm);
    exp_t e;
    reset     = r;
    new_game  = ng;
    guess     = gs;
    cmp_done  = cd;
    cmp_exact = ce;
    e.c  = cyc + 1;
    e.nm = nm;
    e.v  = ev;
    q.push_back(e);
    @(posedge clk);
    #1;
    new_game  = 1'b0;
    guess     = 1'b0;
    cmp_done  = 1'b0;
    cmp_exact = 3'd0;
  endtask

  task automatic start_game(input logic gs_too);
    tick(0, 1, gs_too, 0, 0, o(1,0,0,0,0,0,0,0,3'd1), "gen_first");
    for (int i = 1; i < 4; i++)
      tick(0, (i == 1), (i == 2), (i == 3), 3'd4,
           o(1,0,0,0,0,0,0,0,3'd1), "gen_hold");
    tick(0, 0, 0, 0, 0, o(0,0,0,0,0,0,0,0,3'd2), "gen_to_wait");
  endtask

  task automatic do_guess(input logic [3:0] gc, input logic [2:0] le,
                          input int dly, input logic [2:0] ce,
                          input logic [16:0] after, input logic nz);
    tick(0, 0, 1, 0, 0, o(0,1,0,gc,le,0,0,0,3'd3), "load");
    tick(0, nz, nz, 0, 0, o(0,0,1,gc,le,0,0,0,3'd4), "cmp_start");
    for (int i = 0; i < dly; i++)
      tick(0, nz, nz, 0, 0, o(0,0,0,gc,le,0,0,0,3'd4), "cmp_wait");
    tick(0, 0, 0, 1, ce, after, "cmp_done");
  endtask

  initial begin
    logic [2:0]  le;
    logic [2:0]  ce;
    logic [16:0] af;
    reset = 1'b1;
    new_game = 1'b0;
    guess = 1'b0;
    cmp_done = 1'b0;
    cmp_exact = 3'd0;

    tick(1, 0, 0, 0, 0, '0, "reset0");
    tick(1, 1, 1, 0, 0, '0, "reset1");
    tick(0, 0, 1, 1, 3'd4, '0, "idle_guess");

    // first game: win on second CMP cycle
    start_game(1'b0);
    do_guess(4'd0, 3'd0, 1, 3'd4, o(0,0,0,4'd1,3'd4,1,0,0,3'd5), 1'b0);
    tick(0, 0, 1, 0, 0, o(0,0,0,4'd1,3'd4,1,0,0,3'd5), "win_hold");
    tick(0, 0, 0, 1, 3'd2, o(0,0,0,4'd1,3'd4,1,0,0,3'd5), "win_done");

    // eight misses, one illegal exact value
    start_game(1'b0);
    le = 3'd0;
    for (int i = 0; i < 8; i++) begin
      ce = (i == 3) ? 3'd7 : 3'd2;
      if (i == 7)
        af = o(0,0,0,4'd8,ce,0,1,0,3'd6);
      else
        af = o(0,0,0,4'(i + 1),ce,0,0,0,3'd2);
      do_guess(4'(i), le, 0, ce, af, 1'b0);
      le = ce;
    end
    tick(0, 0, 1, 0, 0, o(0,0,0,4'd8,3'd2,0,1,0,3'd6), "lose_guess");
    tick(0, 0, 0, 1, 3'd4, o(0,0,0,4'd8,3'd2,0,1,0,3'd6), "lose_done");

    // compare timeout after 16 CMP cycles
    start_game(1'b0);
    tick(0, 0, 1, 0, 0, o(0,1,0,0,0,0,0,0,3'd3), "to_load");
    tick(0, 0, 0, 0, 0, o(0,0,1,0,0,0,0,0,3'd4), "to_start");
    for (int i = 1; i < 16; i++)
      tick(0, 0, 0, 0, 0, o(0,0,0,0,0,0,0,0,3'd4), "to_wait");
    tick(0, 0, 0, 0, 0, o(0,0,0,0,0,0,0,1,3'd2), "to_err");
    tick(0, 0, 0, 0, 0, o(0,0,0,0,0,0,0,1,3'd2), "err_hold");
    do_guess(4'd0, 3'd0, 0, 3'd1, o(0,0,0,4'd1,3'd1,0,0,0,3'd2), 1'b0);

    // two more attempts, then new_game and guess together
    do_guess(4'd1, 3'd1, 2, 3'd0, o(0,0,0,4'd2,3'd0,0,0,0,3'd2), 1'b0);
    do_guess(4'd2, 3'd0, 0, 3'd0, o(0,0,0,4'd3,3'd0,0,0,0,3'd2), 1'b0);
    start_game(1'b1);

    // key pulses in LOAD/CMP dropped
    do_guess(4'd0, 3'd0, 1, 3'd3, o(0,0,0,4'd1,3'd3,0,0,0,3'd2), 1'b1);
    tick(0, 0, 0, 0, 0, o(0,0,0,4'd1,3'd3,0,0,0,3'd2), "after_noise");

    // reset mid-CMP, late cmp_done ignored
    tick(0, 0, 1, 0, 0, o(0,1,0,4'd1,3'd3,0,0,0,3'd3), "rst_load");
    tick(0, 0, 0, 0, 0, o(0,0,1,4'd1,3'd3,0,0,0,3'd4), "rst_cmp");
    tick(1, 0, 0, 0, 0, '0, "rst_mid");
    tick(0, 0, 0, 1, 3'd4, '0, "late_done");
    tick(0, 0, 1, 0, 0, '0, "idle_after");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
